remote_cmd_sender: RTL and testbench

//  Host-side command source feeding the robot's UART command receiver.

---
 rtl/remote_cmd_sender.sv | 226 ++++++++++++++++++++++
 tb/tb_remote_cmd_sender.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_sender.sv
// Host-side command source: sends a 16-bit command as two UART bytes (high first),
// then waits for a one-byte response or a timeout. Embeds a simple 8N1 UART.

module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [9:0]    shft;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic          sending;

  // TX is taken straight from a flop so the line never glitches.
  assign tx = shft[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft     <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      sending  <= 1'b0;
      tx_done  <= 1'b0;
    end else if (trmt) begin
      shft     <= {1'b1, tx_data, 1'b0};
      bit_cnt  <= '0;
      baud_cnt <= BW'(BAUD_DIV - 1);
      sending  <= 1'b1;
      tx_done  <= 1'b0;
    end else if (sending) begin
      if (baud_cnt == '0) begin
        shft     <= {1'b1, shft[9:1]};
        baud_cnt <= BW'(BAUD_DIV - 1);
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd9) begin
          sending <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end
endmodule

module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic          rx_ff1, rx_s;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic          receiving;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1    <= 1'b1;
      rx_s      <= 1'b1;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      receiving <= 1'b0;
      rx_data   <= '0;
      rdy       <= 1'b0;
    end else begin
      rx_ff1 <= rx;
      rx_s   <= rx_ff1;
      if (!receiving) begin
        if (!rx_s) begin
          // First sample lands mid start bit, later ones mid bit.
          receiving <= 1'b1;
          bit_cnt   <= '0;
          baud_cnt  <= BW'(BAUD_DIV / 2);
          rdy       <= 1'b0;
        end else if (clr_rdy) begin
          rdy <= 1'b0;
        end
      end else if (baud_cnt == '0) begin
        baud_cnt <= BW'(BAUD_DIV - 1);
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt != 4'd0 && bit_cnt != 4'd9) rx_data <= {rx_s, rx_data[7:1]};
        if (bit_cnt == 4'd9) begin
          receiving <= 1'b0;
          rdy       <= 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end
endmodule

module remote_cmd_sender #(
  parameter int TIMEOUT_CYC = 2**22,
  parameter int BAUD_DIV    = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        resp_tmo,
  output logic [1:0]  dbg_state
);
  // Handshake: snd_cmd is a request accepted only in a cycle where busy is low;
  // cmd is sampled in that same cycle, and requests while busy are dropped.
  typedef enum logic [1:0] {IDLE, SND_HI, SND_LO, WAIT_RESP} state_t;

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state, nxt_state;
  logic [15:0]   cmd_lat;
  logic [CW-1:0] tmo_cnt;
  logic          trmt, tx_done, rx_rdy, clr_rx_rdy;
  logic [7:0]    tx_data, rx_data;
  logic          latch_cmd, capture, snt_set, tmo_set, cnt_inc;

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .tx(TX), .tx_done(tx_done)
  );

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(RX), .clr_rdy(clr_rx_rdy), .rx_data(rx_data), .rdy(rx_rdy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state  = state;
    trmt       = 1'b0;
    tx_data    = cmd_lat[15:8];
    clr_rx_rdy = 1'b0;
    latch_cmd  = 1'b0;
    capture    = 1'b0;
    snt_set    = 1'b0;
    tmo_set    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        clr_rx_rdy = rx_rdy;
        if (snd_cmd) begin
          latch_cmd = 1'b1;
          trmt      = 1'b1;
          tx_data   = cmd[15:8];
          nxt_state = SND_HI;
        end
      end
      SND_HI: begin
        clr_rx_rdy = rx_rdy;
        if (tx_done) begin
          trmt      = 1'b1;
          tx_data   = cmd_lat[7:0];
          nxt_state = SND_LO;
        end
      end
      SND_LO: begin
        clr_rx_rdy = rx_rdy;
        if (tx_done) begin
          snt_set   = 1'b1;
          nxt_state = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response arriving on the last count still wins over the timeout.
        if (rx_rdy) begin
          capture    = 1'b1;
          clr_rx_rdy = 1'b1;
          nxt_state  = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_set   = 1'b1;
          nxt_state = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_lat  <= '0;
      tmo_cnt  <= '0;
      cmd_snt  <= 1'b0;
      resp_tmo <= 1'b0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      cmd_snt  <= snt_set;
      resp_tmo <= tmo_set;
      if (latch_cmd) cmd_lat <= cmd;
      if (state != WAIT_RESP) tmo_cnt <= '0;
      else if (cnt_inc)       tmo_cnt <= tmo_cnt + 1'b1;
      if (capture) resp <= rx_data;
      if (capture)                        resp_rdy <= 1'b1;
      else if (latch_cmd || clr_resp_rdy) resp_rdy <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;
endmodule

// File: tb/tb_remote_cmd_sender.sv
// Directed bench for remote_cmd_sender: command vectors from a table, plus
// hand-written sequences for dropped requests, timeout, unsolicited RX and reset.

module tb_remote_cmd_sender;
  localparam int BAUD = 16;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        clr_resp_rdy = 1'b0;
  logic        rx_line = 1'b1;
  logic        TX, busy, cmd_snt, resp_rdy, resp_tmo;
  logic [7:0]  resp;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  rsp;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_resp;
  } vec_t;

  vec_t vecs[4];

  remote_cmd_sender #(.TIMEOUT_CYC(TMO), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd), .clr_resp_rdy(clr_resp_rdy),
    .RX(rx_line), .TX(TX), .busy(busy), .cmd_snt(cmd_snt), .resp(resp),
    .resp_rdy(resp_rdy), .resp_tmo(resp_tmo), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic send_cmd(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd = 16'hDEAD;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
  endtask

  // Decode one TX frame, returning at mid stop bit.
  task automatic recv_byte(input string name, input logic [7:0] exp);
    logic [7:0] b;
    int n;
    b = 8'h00;
    n = 0;
    while (TX !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (TX !== 1'b0) begin
      check({name, "_start"}, TX, 0);
    end else begin
      repeat (BAUD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk);
        b[i] = TX;
      end
      repeat (BAUD) @(negedge clk);
      check({name, "_stop"}, TX, 1);
      check(name, b, exp);
    end
  endtask

  task automatic wait_snt(input string name);
    int n;
    n = 0;
    while (cmd_snt !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_snt"}, cmd_snt, 1);
    check({name, "_busy_wait"}, busy, 1);
    @(negedge clk);
    check({name, "_snt_width"}, cmd_snt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, lows;

    vecs[0] = '{cmd: 16'h2A5C, rsp: 8'hA5, exp_hi: 8'h2A, exp_lo: 8'h5C, exp_resp: 8'hA5};
    vecs[1] = '{cmd: 16'h0000, rsp: 8'h00, exp_hi: 8'h00, exp_lo: 8'h00, exp_resp: 8'h00};
    vecs[2] = '{cmd: 16'hFFFF, rsp: 8'h5A, exp_hi: 8'hFF, exp_lo: 8'hFF, exp_resp: 8'h5A};
    vecs[3] = '{cmd: 16'h8001, rsp: 8'h3C, exp_hi: 8'h80, exp_lo: 8'h01, exp_resp: 8'h3C};

    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_snt", cmd_snt, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_rdy", resp_rdy, 0);
    check("rst_tmo", resp_tmo, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven command / response round trips
    for (int v = 0; v < 4; v++) begin
      send_cmd(vecs[v].cmd);
      check($sformatf("v%0d_busy", v), busy, 1);
      recv_byte($sformatf("v%0d_hi", v), vecs[v].exp_hi);
      check($sformatf("v%0d_busy_mid", v), busy, 1);
      recv_byte($sformatf("v%0d_lo", v), vecs[v].exp_lo);
      wait_snt($sformatf("v%0d", v));
      send_rx(vecs[v].rsp);
      @(negedge clk);
      check($sformatf("v%0d_resp", v), resp, vecs[v].exp_resp);
      check($sformatf("v%0d_rdy", v), resp_rdy, 1);
      check($sformatf("v%0d_idle", v), busy, 0);
      pulse_clr();
      check($sformatf("v%0d_rdy_clr", v), resp_rdy, 0);
      check($sformatf("v%0d_resp_hold", v), resp, vecs[v].exp_resp);
    end

    // Request during SND_LO is dropped
    send_cmd(16'h1234);
    recv_byte("drop_hi", 8'h12);
    fork
      recv_byte("drop_lo", 8'h34);
      begin
        repeat (30) @(negedge clk);
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
      end
    join
    wait_snt("drop");
    send_rx(8'hA5);
    @(negedge clk);
    check("drop_resp", resp, 8'hA5);
    check("drop_rdy", resp_rdy, 1);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    check("drop_tx_quiet", lows, 0);
    check("drop_idle", busy, 0);

    // No response: timeout 1000 cycles after entering WAIT_RESP
    send_cmd(16'h0F0F);
    check("tmo_rdy_cleared", resp_rdy, 0);
    recv_byte("tmo_hi", 8'h0F);
    recv_byte("tmo_lo", 8'h0F);
    n = 0;
    while (cmd_snt !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_snt", cmd_snt, 1);
    t0 = cyc;
    n = 0;
    while (resp_tmo !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    check("tmo_seen", resp_tmo, 1);
    check("tmo_delay", t1 - t0, TMO);
    check("tmo_idle", busy, 0);
    check("tmo_rdy", resp_rdy, 0);
    check("tmo_resp", resp, 8'hA5);
    @(negedge clk);
    check("tmo_width", resp_tmo, 0);

    // Unsolicited byte while idle is discarded
    send_rx(8'h77);
    repeat (4) @(negedge clk);
    check("unsol_resp", resp, 8'hA5);
    check("unsol_rdy", resp_rdy, 0);
    check("unsol_idle", busy, 0);
    send_cmd(16'h5500);
    recv_byte("unsol_hi", 8'h55);
    recv_byte("unsol_lo", 8'h00);
    wait_snt("unsol");
    send_rx(8'hA5);
    @(negedge clk);
    check("unsol_next_resp", resp, 8'hA5);
    check("unsol_next_rdy", resp_rdy, 1);

    // Asynchronous reset in the middle of the high byte
    send_cmd(16'h00FF);
    repeat (40) @(negedge clk);
    check("rstmid_tx_low", TX, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx", TX, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_snt", cmd_snt, 0);
    check("rstmid_resp", resp, 8'h00);
    check("rstmid_rdy", resp_rdy, 0);
    check("rstmid_tmo", resp_tmo, 0);
    check("rstmid_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_cmd(16'h0001);
    recv_byte("post_hi", 8'h00);
    recv_byte("post_lo", 8'h01);
    wait_snt("post");
    send_rx(8'hA5);
    @(negedge clk);
    check("post_resp", resp, 8'hA5);
    check("post_rdy", resp_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
